// File: rtl/pad_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// pad_pkg : shared state encoding, default geometry, width helper
// Rev 1.0
// ---------------------------------------------------------------
package pad_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam int DEF_DW    = 16;
  localparam int DEF_IMG_W = 416;
  localparam int DEF_IMG_H = 416;
  localparam int DEF_PAD   = 1;

  // Counter width for a dimension of n positions; never narrower than 1 bit.
  function automatic int pad_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_ROWS = DEF_IMG_H + 2 * DEF_PAD;
  localparam int DEF_COLS = DEF_IMG_W + 2 * DEF_PAD;
  localparam int DEF_CW   = pad_width(DEF_ROWS);
  localparam int DEF_CW2  = pad_width(DEF_COLS);

endpackage
`default_nettype wire

// File: rtl/pad_pos_counter.sv
`default_nettype none
// ---------------------------------------------------------------
// pad_pos_counter : row/col raster counter with advance and clear
// Rev 1.0
// ---------------------------------------------------------------
module pad_pos_counter
  import pad_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int RW   = DEF_CW,
  parameter int CLW  = DEF_CW2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           advance,
  output logic [RW-1:0]  row,
  output logic [CLW-1:0] col,
  output logic           is_last
);

  localparam logic [RW-1:0]  ROW_MAX = RW'(ROWS - 1);
  localparam logic [CLW-1:0] COL_MAX = CLW'(COLS - 1);

  // Wrapping at the final position returns the counter to origin on its own.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign is_last = (row == ROW_MAX) && (col == COL_MAX);

endmodule
`default_nettype wire

// File: rtl/pad_frame_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------
// pad_frame_ctrl : handshaked frame sequencer injecting zero border
// Rev 1.0
// ---------------------------------------------------------------
module pad_frame_ctrl
  import pad_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int PAD   = DEF_PAD,
  localparam int ROWS = IMG_H + 2 * PAD,
  localparam int COLS = IMG_W + 2 * PAD,
  localparam int CW   = pad_width(ROWS),
  localparam int CW2  = pad_width(COLS)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW-1:0]  in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_data,
  output logic           out_pad,
  output logic           out_last,
  output logic [CW-1:0]  row,
  output logic [CW2-1:0] col,
  output logic           busy,
  output logic           done
);

  state_t state;
  logic   run;
  logic   pad;
  logic   is_last;
  logic   xfer;

  assign run  = (state == ST_RUN);
  assign xfer = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start) state <= ST_RUN;
        ST_RUN:  if (xfer && is_last) state <= ST_DONE;
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  pad_pos_counter #(
    .ROWS (ROWS),
    .COLS (COLS),
    .RW   (CW),
    .CLW  (CW2)
  ) u_pos (
    .clk     (clk),
    .reset   (reset),
    .clear   (!run),
    .advance (xfer),
    .row     (row),
    .col     (col),
    .is_last (is_last)
  );

  // With no border the comparisons against zero would be constant, so skip them.
  generate
    if (PAD > 0) begin : g_pad
      localparam logic [CW-1:0]  ROW_LO = CW'(PAD);
      localparam logic [CW-1:0]  ROW_HI = CW'(IMG_H + PAD);
      localparam logic [CW2-1:0] COL_LO = CW2'(PAD);
      localparam logic [CW2-1:0] COL_HI = CW2'(IMG_W + PAD);
      assign pad = (row < ROW_LO) || (row >= ROW_HI) ||
                   (col < COL_LO) || (col >= COL_HI);
    end else begin : g_nopad
      assign pad = 1'b0;
    end
  endgenerate

  assign out_valid = run && (pad || in_valid);
  assign in_ready  = run && !pad && out_ready;
  assign out_data  = (run && !pad) ? in_data : '0;
  assign out_pad   = run && pad;
  assign out_last  = run && is_last;
  assign busy      = run;
  assign done      = (state == ST_DONE);

endmodule
`default_nettype wire

// File: doc/pad_frame_ctrl.md
Name: pad_frame_ctrl

Overview:
- Sequences the padding layer over one feature-map plane per `start` pulse.
- Walks row/column counters across the padded frame of (IMG_H+2·PAD) x (IMG_W+2·PAD) positions.
- At border positions it injects zero beats and does not consume input; at interior positions it forwards the upstream pixel stream.
- Sits between the line/feature buffer read side and the downstream conv-window stage, replacing the free-running pixel counter with a handshaked, frame-aware sequencer.

Parameters:
- DW, 16: pixel data width.
- IMG_W, 416: unpadded frame width in pixels.
- IMG_H, 416: unpadded frame height in pixels.
- PAD, 1: zero-border thickness on every side, in pixels; legal range 0..7.

Ports:
- clk, input, 1: clock; all logic on rising edge.
- reset, input, 1: synchronous, active-low reset.
- start, input, 1: begin one frame; sampled only in IDLE.
- in_valid, input, 1: upstream pixel valid.
- in_ready, output, 1: upstream pixel accepted when in_valid && in_ready.
- in_data, input, DW: upstream pixel.
- out_valid, output, 1: padded pixel valid.
- out_ready, input, 1: downstream accept.
- out_data, output, DW: padded pixel (0 on border).
- out_pad, output, 1: current beat is a border beat.
- out_last, output, 1: final beat of the padded frame.
- row, output, CW: current padded row, CW = $clog2(IMG_H+2·PAD).
- col, output, CW2: current padded column, CW2 = $clog2(IMG_W+2·PAD).
- busy, output, 1: high in RUN.
- done, output, 1: one-cycle pulse after the last beat transfers.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE; row=0, col=0; done=0.
  - All combinational outputs follow from this: out_valid=0, in_ready=0, busy=0, out_pad=0, out_last=0, out_data=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 → RUN next cycle with row=col=0.
  - All other inputs are ignored; in_ready=0, out_valid=0.
- RUN, position classification:
  - pad = (row<PAD) | (row>=IMG_H+PAD) | (col<PAD) | (col>=IMG_W+PAD).
- RUN, pad beat:
  - out_valid=1, out_data=0, in_ready=0.
  - Upstream data is never consumed.
- RUN, interior beat:
  - out_valid=in_valid, out_data=in_data, in_ready=out_ready.
  - Combinational pass-through, zero latency, no skid buffer.
- Advance occurs only on out_valid && out_ready:
  - col increments.
  - At col==IMG_W+2·PAD-1, col wraps to 0 and row increments.
- out_last=1 when in RUN with row==IMG_H+2·PAD-1 and col==IMG_W+2·PAD-1.
- When the last beat transfers: state → DONE, row/col → 0.
- DONE: done=1 for exactly one cycle, then IDLE. start asserted in DONE is ignored.
- start while RUN or DONE: ignored; no restart, no error.
- Backpressure (out_ready=0): position is held and out_data/out_pad stay stable; on interior beats in_ready=0.
- Upstream starvation (in_valid=0 on an interior beat): out_valid=0 and position is held. Pad beats continue regardless of in_valid.
- PAD=0: no pad beats; the block acts as a counted pass-through of IMG_W·IMG_H beats.
- Reset mid-frame: immediate return to IDLE, counters cleared, no done pulse. Remaining input beats are the upstream's responsibility to flush.
- Counter widths: no overflow is possible; row and col never exceed dims-1.
- Total per frame:
  - Beats = (IMG_H+2·PAD)·(IMG_W+2·PAD).
  - Input beats consumed = IMG_H·IMG_W, exactly.

Decomposition:
- Shared package `pad_pkg`:
  - State enum (IDLE/RUN/DONE).
  - Default IMG_W/IMG_H/PAD constants.
  - Derived padded-dimension and width localparams.
- One natural sub-module: `pad_pos_counter`.
  - Handles the row/col wrap counter with advance enable and clear.
  - Outputs row, col and an is_last flag.
- The FSM, pad classification and handshake muxing stay in the top.

Test Plan:
1. IMG_W=4, IMG_H=3, PAD=1; start, out_ready=1, in_valid=1 with data 1..12 → 30 out beats.
   - Beats 0–6 are zero with out_pad=1; beat 7 = 1.
   - Row 1 reads 0,1,2,3,4,0.
   - out_last on beat 29; done one cycle later; in_ready high for exactly 12 cycles.
2. Same config, out_ready toggling 1,0,1,0 → out_data stable during low cycles; beat sequence identical to scenario 1; in_ready=0 whenever out_ready=0.
3. Same config, in_valid low for 3 cycles at row 2 col 2 → out_valid=0 for those 3 cycles, row/col held; border beats before that point are unaffected.
4. start pulsed at beat 10 while RUN → no restart; frame still ends at beat 29 with a single done.
5. reset=0 asserted at row 2 col 3 → next cycle IDLE, row=col=0, busy=0, no done; a following start runs a full 30-beat frame.
6. PAD=0, IMG_W=4, IMG_H=3 → 12 beats, out_pad never high, out_data equals in_data 1..12, out_last on beat 11.
